// File: rtl/anim_pkg.sv
// Shared types and constants for the fighter animation sequencer.
// Optional build macro: ANIM_ROM_ADDR_EN (sprite ROM address generation).
package anim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WALK  = 3'd1,
    ST_JUMP  = 3'd2,
    ST_PUNCH = 3'd3,
    ST_HURT  = 3'd4
  } anim_state_e;

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_WALK  = 2'd1;
  localparam logic [1:0] CMD_JUMP  = 2'd2;
  localparam logic [1:0] CMD_PUNCH = 2'd3;

  localparam int SPR_W = 60;
  localparam int SPR_H = 90;
  localparam int BOX_W = 80;
  localparam int BOX_H = 160;

  function automatic anim_state_e cmd_to_state(input logic [1:0] cmd_v);
    anim_state_e st_v;
    case (cmd_v)
      CMD_IDLE:  st_v = ST_IDLE;
      CMD_WALK:  st_v = ST_WALK;
      CMD_JUMP:  st_v = ST_JUMP;
      CMD_PUNCH: st_v = ST_PUNCH;
      default:   st_v = ST_IDLE;
    endcase
    return st_v;
  endfunction

  function automatic logic is_one_shot(input anim_state_e st_v);
    logic os_v;
    case (st_v)
      ST_JUMP, ST_PUNCH, ST_HURT: os_v = 1'b1;
      default:                    os_v = 1'b0;
    endcase
    return os_v;
  endfunction

endpackage

// File: rtl/fighter_anim_seq_if.sv
// Game-logic <-> animation sequencer signal bundle.
// Optional build macro: ANIM_ROM_ADDR_EN adds the sprite-position/ROM-address signals.
interface fighter_anim_seq_if;
  import anim_pkg::*;

  logic        frame_tick;
  logic [1:0]  cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        facing_left;
  logic        hit;
  anim_state_e anim_state;
  logic [1:0]  frame_idx;
  logic        mirror;
  logic        busy;
  logic        anim_done;
`ifdef ANIM_ROM_ADDR_EN
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [9:0]  spr_x;
  logic [9:0]  spr_y;
  logic [12:0] rom_address;
  logic        in_box;
`endif

  modport master (
    output frame_tick, cmd, cmd_valid, facing_left, hit,
`ifdef ANIM_ROM_ADDR_EN
    output DrawX, DrawY, spr_x, spr_y,
    input  rom_address, in_box,
`endif
    input  cmd_ready, anim_state, frame_idx, mirror, busy, anim_done
  );

  modport slave (
    input  frame_tick, cmd, cmd_valid, facing_left, hit,
`ifdef ANIM_ROM_ADDR_EN
    input  DrawX, DrawY, spr_x, spr_y,
    output rom_address, in_box,
`endif
    output cmd_ready, anim_state, frame_idx, mirror, busy, anim_done
  );

endinterface

// File: rtl/anim_rom_addr.sv
// Scales the pixel offset inside the 80x160 on-screen box to the 60x90 sprite ROM, with mirroring.
// Only instantiated when ANIM_ROM_ADDR_EN is defined.
module anim_rom_addr
  import anim_pkg::*;
(
  input  logic        vga_clk,
  input  logic        reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  spr_x,
  input  logic [9:0]  spr_y,
  input  logic        mirror,
  output logic [12:0] rom_address,
  output logic        in_box
);

  logic [9:0]  rel_x_s;
  logic [9:0]  rel_y_s;
  logic        in_box_s;
  logic [12:0] col_s;
  logic [12:0] row_s;
  logic [12:0] col_sel_s;
  logic [12:0] addr_s;
  logic [12:0] rom_address_r;
  logic        in_box_r;

  // Offset, box test and scaled column/row; pixels left of/above the sprite wrap large and fall outside.
  always_comb begin
    rel_x_s   = DrawX - spr_x;
    rel_y_s   = DrawY - spr_y;
    in_box_s  = (rel_x_s < 10'(BOX_W)) && (rel_y_s < 10'(BOX_H));
    col_s     = 13'((17'(rel_x_s) * 17'(SPR_W)) / 17'(BOX_W));
    row_s     = 13'((17'(rel_y_s) * 17'(SPR_H)) / 17'(BOX_H));
    col_sel_s = mirror ? (13'(SPR_W - 1) - col_s) : col_s;
    if (in_box_s) begin
      addr_s = col_sel_s + (row_s * 13'(SPR_W));
    end else begin
      addr_s = 13'd0;
    end
  end

  // Address register: the ROM downstream samples it on the falling edge.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rom_address_r <= 13'd0;
      in_box_r      <= 1'b0;
    end else begin
      rom_address_r <= addr_s;
      in_box_r      <= in_box_s;
    end
  end

  assign rom_address = rom_address_r;
  assign in_box      = in_box_r;

endmodule

// File: rtl/fighter_anim_seq.sv
// Per-fighter animation sequencer: state, frame index and mirror, advanced by frame_tick.
// Optional build macro: ANIM_ROM_ADDR_EN instantiates anim_rom_addr for sprite ROM addressing.
module fighter_anim_seq
  import anim_pkg::*;
#(
  parameter int HOLD_FRAMES  = 6,
  parameter int WALK_FRAMES  = 4,
  parameter int JUMP_FRAMES  = 3,
  parameter int PUNCH_FRAMES = 3,
  parameter int HURT_FRAMES  = 2
) (
  input  logic             vga_clk,
  input  logic             reset,
  fighter_anim_seq_if.slave bus
);

  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [1:0] WALK_LAST = 2'(WALK_FRAMES - 1);

  anim_state_e       state_r, next_state_s, cmd_state_s;
  logic [1:0]        frame_r, frame_next_s;
  logic [HOLD_W-1:0] hold_r, hold_next_s;
  logic              mirror_r, mirror_next_s;
  logic              done_r, done_next_s;
  logic              busy_r;
  logic              cmd_ready_s;

  function automatic logic [1:0] last_frame(input anim_state_e st_v);
    logic [1:0] lf_v;
    case (st_v)
      ST_JUMP:  lf_v = 2'(JUMP_FRAMES - 1);
      ST_PUNCH: lf_v = 2'(PUNCH_FRAMES - 1);
      ST_HURT:  lf_v = 2'(HURT_FRAMES - 1);
      default:  lf_v = 2'd0;
    endcase
    return lf_v;
  endfunction

  // Next-state logic: hit beats commands, commands beat ticks; a same-state command changes nothing.
  always_comb begin
    next_state_s  = state_r;
    frame_next_s  = frame_r;
    hold_next_s   = hold_r;
    mirror_next_s = mirror_r;
    done_next_s   = 1'b0;
    cmd_state_s   = cmd_to_state(bus.cmd);
    cmd_ready_s   = ((state_r == ST_IDLE) || (state_r == ST_WALK)) && !bus.hit;

    if (bus.hit) begin
      next_state_s  = ST_HURT;
      frame_next_s  = 2'd0;
      hold_next_s   = '0;
      mirror_next_s = bus.facing_left;
    end else if (bus.cmd_valid && cmd_ready_s && (cmd_state_s != state_r)) begin
      next_state_s  = cmd_state_s;
      frame_next_s  = 2'd0;
      hold_next_s   = '0;
      mirror_next_s = bus.facing_left;
    end else begin
      // Facing is frozen for the whole of a one-shot.
      if (is_one_shot(state_r)) begin
        mirror_next_s = mirror_r;
      end else begin
        mirror_next_s = bus.facing_left;
      end
      if (bus.frame_tick) begin
        if (hold_r == HOLD_LAST) begin
          hold_next_s = '0;
          case (state_r)
            ST_IDLE: frame_next_s = 2'd0;
            ST_WALK: frame_next_s = (frame_r == WALK_LAST) ? 2'd0 : frame_r + 2'd1;
            ST_JUMP, ST_PUNCH, ST_HURT: begin
              if (frame_r == last_frame(state_r)) begin
                next_state_s = ST_IDLE;
                frame_next_s = 2'd0;
                done_next_s  = 1'b1;
              end else begin
                frame_next_s = frame_r + 2'd1;
              end
            end
            default: begin
              next_state_s = ST_IDLE;
              frame_next_s = 2'd0;
            end
          endcase
        end else begin
          hold_next_s = hold_r + HOLD_W'(1);
        end
      end else begin
        hold_next_s = hold_r;
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      frame_r  <= 2'd0;
      hold_r   <= '0;
      mirror_r <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      frame_r  <= frame_next_s;
      hold_r   <= hold_next_s;
      mirror_r <= mirror_next_s;
      done_r   <= done_next_s;
      busy_r   <= is_one_shot(next_state_s);
    end
  end

  assign bus.cmd_ready  = cmd_ready_s;
  assign bus.anim_state = state_r;
  assign bus.frame_idx  = frame_r;
  assign bus.mirror     = mirror_r;
  assign bus.busy       = busy_r;
  assign bus.anim_done  = done_r;

`ifdef ANIM_ROM_ADDR_EN
  anim_rom_addr u_rom_addr (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (bus.DrawX),
    .DrawY       (bus.DrawY),
    .spr_x       (bus.spr_x),
    .spr_y       (bus.spr_y),
    .mirror      (mirror_r),
    .rom_address (bus.rom_address),
    .in_box      (bus.in_box)
  );
`endif

endmodule
